// File: rtl/pdm_decim.sv
// PDM-to-PCM decimator: counts ones over a window of DECIM microphone bits,
// scales them to a saturated 16-bit PCM sample and queues it in a small FIFO.
module pdm_decim #(
  parameter int DECIM      = 64,
  parameter int WARMUP     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        en,
  input  logic        mic_data,
  output logic        mic_lrsel,
  output logic [15:0] pcm_data,
  output logic        pcm_valid,
  input  logic        pcm_ready,
  output logic        overflow,
  output logic [2:0]  fifo_level
);

  localparam int LOG2D = $clog2(DECIM);
  localparam int SHIFT = 15 - LOG2D;
  localparam int WCW   = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam logic [WCW-1:0]     WARM_LAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [LOG2D-1:0]   WIN_LAST  = LOG2D'(DECIM - 1);
  localparam logic signed [17:0] DECIM_S   = 18'(DECIM);
  localparam logic [2:0]         FULL_LVL  = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [LOG2D-1:0]    win_cnt_r;
  logic [LOG2D:0]      ones_r, ones_total_s;
  logic [WCW-1:0]      warm_cnt_r;
  logic                capture_s, win_close_s, emit_s, start_s;
  logic signed [17:0]  ones_ext_s, diff_s, scaled_s;
  logic [15:0]         sample_r;
  logic                push_r, pop_s, push_ok_s;
  logic [15:0]         mem_r [FIFO_DEPTH];
  logic [PW-1:0]       rd_ptr_r, wr_ptr_r;
  logic [2:0]          level_r, level_s;
  logic                overflow_r;

  // Clamp the scaled window sum into the signed 16-bit range.
  function automatic logic [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767) begin
      sat16 = 16'h7FFF;
    end else if (v < -18'sd32768) begin
      sat16 = 16'h8000;
    end else begin
      sat16 = v[15:0];
    end
  endfunction

  // State register.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; en low always returns to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_s = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WARMUP: begin
        if (!en) begin
          state_s = ST_IDLE;
        end else if (win_close_s && (warm_cnt_r == WARM_LAST)) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_WARMUP;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State-decoded controls; a bit is only captured while en is still high.
  always_comb begin
    capture_s   = 1'b0;
    start_s     = 1'b0;
    case (state_r)
      ST_IDLE:   start_s   = en;
      ST_WARMUP: capture_s = en;
      ST_RUN:    capture_s = en;
      default:   capture_s = 1'b0;
    endcase
    win_close_s = capture_s && (win_cnt_r == WIN_LAST);
    emit_s      = win_close_s && (state_r == ST_RUN);
  end

  // Window sum including the bit captured on this edge, scaled to full range.
  always_comb begin
    ones_total_s = ones_r + {{LOG2D{1'b0}}, mic_data};
    ones_ext_s   = signed'({{(17 - LOG2D){1'b0}}, ones_total_s});
    diff_s       = (ones_ext_s <<< 1) - DECIM_S;
    scaled_s     = diff_s <<< SHIFT;
  end

  // Window, ones and warm-up counters; cleared whenever capture is idle.
  always_ff @(posedge mclk) begin
    if (reset || state_r == ST_IDLE || state_s == ST_IDLE) begin
      win_cnt_r  <= '0;
      ones_r     <= '0;
      warm_cnt_r <= '0;
    end else if (capture_s) begin
      if (win_close_s) begin
        win_cnt_r <= '0;
        ones_r    <= '0;
        if (state_r == ST_WARMUP) begin
          warm_cnt_r <= warm_cnt_r + WCW'(1);
        end
      end else begin
        win_cnt_r <= win_cnt_r + LOG2D'(1);
        ones_r    <= ones_total_s;
      end
    end
  end

  // One-cycle staging between window close and FIFO push.
  always_ff @(posedge mclk) begin
    if (reset) begin
      push_r   <= 1'b0;
      sample_r <= 16'h0000;
    end else begin
      push_r <= emit_s;
      if (emit_s) begin
        sample_r <= sat16(scaled_s);
      end
    end
  end

  // A push into a full FIFO only lands when a pop frees the head slot.
  always_comb begin
    pop_s     = pcm_valid && pcm_ready;
    push_ok_s = push_r && ((level_r != FULL_LVL) || pop_s);
    level_s   = level_r;
    case ({push_ok_s, pop_s})
      2'b10:   level_s = level_r + 3'd1;
      2'b01:   level_s = level_r - 3'd1;
      default: level_s = level_r;
    endcase
  end

  // FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge mclk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 16'h0000;
      end
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      level_r    <= 3'd0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= sample_r;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      level_r <= level_s;
      if (start_s) begin
        overflow_r <= 1'b0;
      end else if (push_r && !push_ok_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign mic_lrsel  = 1'b0;
  assign pcm_valid  = (level_r != 3'd0);
  assign pcm_data   = mem_r[rd_ptr_r];
  assign overflow   = overflow_r;
  assign fifo_level = level_r;

endmodule

// File: tb/tb_pdm_decim.sv
// Directed bench for pdm_decim at default parameters (DECIM=64, WARMUP=4).
module tb_pdm_decim;

  logic        mclk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        mic_data = 1'b0;
  logic        pcm_ready = 1'b0;
  logic        mic_lrsel;
  logic [15:0] pcm_data;
  logic        pcm_valid;
  logic        overflow;
  logic [2:0]  fifo_level;

  int passed = 0;
  int total  = 0;
  int ecount = 0;
  logic [15:0] exp_tab [5] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h4000, 16'hC000};

  pdm_decim dut (
    .mclk(mclk), .reset(reset), .en(en), .mic_data(mic_data),
    .mic_lrsel(mic_lrsel), .pcm_data(pcm_data), .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 mclk = ~mclk;

  // kind: 0 all ones, 1 all zeros, 2 alternating 1/0, 3 48 ones, 4 16 ones
  function automatic logic pat_bit(input int kind, input int idx);
    case (kind)
      0: return 1'b1;
      1: return 1'b0;
      2: return (idx % 2 == 0);
      3: return (idx < 48);
      4: return (idx < 16);
      default: return 1'b1;
    endcase
  endfunction

  // Four warm-up windows, then one RUN window of each kind in turn.
  function automatic int sched_kind(input int wn);
    if (wn < 4 || wn > 8) return 0;
    return wn - 4;
  endfunction

  task automatic cyc(input logic b);
    mic_data = b;
    @(posedge mclk);
    #1;
    ecount++;
  endtask

  task automatic run_to(input int kind, input int target);
    int k;
    while (ecount < target) begin
      k = (kind < 0) ? sched_kind(ecount / 64) : kind;
      cyc(pat_bit(k, ecount % 64));
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  task automatic start_capture();
    en = 1'b0;
    reset = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    reset = 1'b0;
    cyc(1'b0);
    en = 1'b1;
    cyc(1'b0);
    ecount = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; mic_data = 1'b1; pcm_ready = 1'b1;
    repeat (3) cyc(1'b1);
    chk("reset_valid", 16'(pcm_valid), 16'h0);
    chk("reset_data", pcm_data, 16'h0000);
    chk("reset_level", 16'(fifo_level), 16'h0);
    chk("reset_overflow", 16'(overflow), 16'h0);
    chk("reset_lrsel", 16'(mic_lrsel), 16'h0);
    reset = 1'b0; en = 1'b0;
  endtask

  task automatic test_pattern(input int kind, input logic [15:0] exp);
    start_capture();
    pcm_ready = 1'b1;
    run_to(kind, 320);
    chk("pat_early_valid", 16'(pcm_valid), 16'h0);
    run_to(kind, 321);
    chk("pat_first_valid", 16'(pcm_valid), 16'h1);
    chk("pat_first_data", pcm_data, exp);
    run_to(kind, 322);
    chk("pat_popped", 16'(pcm_valid), 16'h0);
    run_to(kind, 384);
    chk("pat_gap_valid", 16'(pcm_valid), 16'h0);
    run_to(kind, 385);
    chk("pat_second_valid", 16'(pcm_valid), 16'h1);
    chk("pat_second_data", pcm_data, exp);
  endtask

  task automatic test_overflow();
    start_capture();
    pcm_ready = 1'b0;
    run_to(-1, 513);
    chk("ovf_level4", 16'(fifo_level), 16'd4);
    chk("ovf_not_yet", 16'(overflow), 16'h0);
    chk("ovf_head_a", pcm_data, 16'h7FFF);
    run_to(-1, 577);
    chk("ovf_level_kept", 16'(fifo_level), 16'd4);
    chk("ovf_set", 16'(overflow), 16'h1);
    chk("ovf_head_stable", pcm_data, 16'h7FFF);
    pcm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_pop_order", pcm_data, exp_tab[i]);
      cyc(1'b1);
    end
    chk("ovf_drained", 16'(fifo_level), 16'd0);
    chk("ovf_sticky", 16'(overflow), 16'h1);
  endtask

  task automatic test_en_drop();
    logic seen;
    run_to(-1, 641);
    chk("drop_prev_sample", pcm_data, 16'h7FFF);
    run_to(-1, 670);
    en = 1'b0;
    cyc(1'b1);
    seen = 1'b0;
    repeat (80) begin
      cyc(1'b1);
      if (pcm_valid) seen = 1'b1;
    end
    chk("drop_no_sample", 16'(seen), 16'h0);
    chk("drop_ovf_kept", 16'(overflow), 16'h1);
    en = 1'b1;
    cyc(1'b1);
    ecount = 0;
    chk("rerise_ovf_clr", 16'(overflow), 16'h0);
    run_to(0, 320);
    chk("rerise_early", 16'(pcm_valid), 16'h0);
    run_to(0, 321);
    chk("rerise_valid", 16'(pcm_valid), 16'h1);
    chk("rerise_data", pcm_data, 16'h7FFF);
  endtask

  task automatic test_full_push_pop();
    start_capture();
    pcm_ready = 1'b0;
    run_to(-1, 576);
    chk("full_level", 16'(fifo_level), 16'd4);
    pcm_ready = 1'b1;
    run_to(-1, 577);
    pcm_ready = 1'b0;
    chk("full_pp_level", 16'(fifo_level), 16'd4);
    chk("full_pp_ovf", 16'(overflow), 16'h0);
    chk("full_pp_head", pcm_data, 16'h8000);
  endtask

  task automatic test_reset_drain();
    start_capture();
    pcm_ready = 1'b0;
    run_to(-1, 577);
    pcm_ready = 1'b1;
    run_to(-1, 579);
    chk("rd_level2", 16'(fifo_level), 16'd2);
    chk("rd_ovf_pre", 16'(overflow), 16'h1);
    reset = 1'b1;
    cyc(1'b1);
    chk("rd_valid", 16'(pcm_valid), 16'h0);
    chk("rd_level", 16'(fifo_level), 16'd0);
    chk("rd_ovf", 16'(overflow), 16'h0);
    chk("rd_data", pcm_data, 16'h0000);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_window();
    logic seen;
    start_capture();
    pcm_ready = 1'b1;
    run_to(0, 350);
    reset = 1'b1;
    cyc(1'b1);
    reset = 1'b0;
    cyc(1'b1);
    ecount = 0;
    seen = 1'b0;
    while (ecount < 320) begin
      cyc(1'b0);
      if (pcm_valid) seen = 1'b1;
    end
    chk("mid_no_stale", 16'(seen), 16'h0);
    run_to(1, 321);
    chk("mid_new_sample", pcm_data, 16'h8000);
  endtask

  initial begin
    test_reset();
    test_pattern(0, 16'h7FFF);
    test_pattern(1, 16'h8000);
    test_pattern(2, 16'h0000);
    test_pattern(3, 16'h4000);
    test_overflow();
    test_en_drop();
    test_full_push_pop();
    test_reset_drain();
    test_reset_mid_window();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
